// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   RV32I instruction fetch stage. Holds the fetch PC, issues word requests to
//   instruction memory over req/gnt/rvalid, buffers returned words together with
//   their PC in a small FIFO and presents the head to decode with valid/ready.
//   A redirect (taken branch/jump) flushes the buffer, retargets the PC and
//   drains any wrong-path responses still in flight.
//
// Ports
//   i_clk, i_rst_n        clock (rising edge), async active-low reset
//   i_pc_sel, i_alu_data  redirect request and target address
//   o_imem_addr/o_imem_req, i_imem_gnt          request channel
//   i_imem_rvalid, i_imem_rdata                 in-order response channel
//   o_instruction, o_pc, o_insn_vld, i_dec_rdy  decode interface (FIFO head)
//   o_misalign            1-cycle pulse when a redirect target is not word aligned
//
// state | meaning
// ------+----------------------------------------------------------------------
// IDLE  | first cycle after reset release, no requests
// RUN   | fetching; requests issued while outstanding + buffered < FIFO_DEPTH
// DRAIN | after a redirect, discarding wrong-path responses until none remain
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_pc_sel,
    input  logic [31:0] i_alu_data,
    output logic [31:0] o_imem_addr,
    output logic        o_imem_req,
    input  logic        i_imem_gnt,
    input  logic        i_imem_rvalid,
    input  logic [31:0] i_imem_rdata,
    output logic [31:0] o_instruction,
    output logic [31:0] o_pc,
    output logic        o_insn_vld,
    input  logic        i_dec_rdy,
    output logic        o_misalign
);

    localparam int          CW      = $clog2(FIFO_DEPTH + 1);
    localparam int          PW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [31:0] NOP     = 32'h0000_0013;
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(FIFO_DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(FIFO_DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN
    } state_e;

    state_e         state_q, state_d;
    logic [31:0]    pc_req_q, pc_req_d;
    logic [CW-1:0]  outst_q, outst_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic           mis_q, mis_d;

    logic [31:0]    fifo_insn_q [FIFO_DEPTH];
    logic [31:0]    fifo_pc_q   [FIFO_DEPTH];

    logic           redirect;
    logic           pop;
    logic           gnt_acc;
    logic           rsp;
    logic           push;
    logic [CW:0]    occupancy;
    logic [31:0]    pc_rsp;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign redirect = i_pc_sel && (state_q != S_IDLE);
    assign pop      = (cnt_q != '0) && i_dec_rdy;

    // A word leaving the buffer this cycle frees its slot for a new request,
    // which keeps a 2-deep buffer streaming one instruction per cycle. The
    // freed credit only moves into cnt_q at the edge, so a raised request
    // never loses eligibility before it is granted.
    assign occupancy  = {1'b0, outst_q} + {1'b0, cnt_q} - {{CW{1'b0}}, pop};
    assign o_imem_req = (state_q == S_RUN) && (occupancy < DEPTH_C);
    assign gnt_acc    = o_imem_req && i_imem_gnt;

    assign rsp  = i_imem_rvalid && (outst_q != '0) && (state_q != S_IDLE);
    assign push = rsp && (state_q == S_RUN) && !redirect;

    // In RUN the outstanding requests are always the contiguous words just
    // below pc_req_q; any redirect with traffic in flight goes through DRAIN.
    assign pc_rsp = pc_req_q - 32'({outst_q, 2'b00});

    always_comb begin
        state_d  = state_q;
        pc_req_d = pc_req_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        outst_d  = outst_q + CW'(gnt_acc) - CW'(rsp);
        mis_d    = redirect && (i_alu_data[1:0] != 2'b00);

        if (redirect) begin
            pc_req_d = {i_alu_data[31:2], 2'b00};
        end else if (gnt_acc) begin
            pc_req_d = pc_req_q + 32'd4;
        end

        if (redirect) begin
            cnt_d    = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            cnt_d = cnt_q + CW'(push) - CW'(pop);
        end

        case (state_q)
            S_IDLE:  state_d = S_RUN;
            S_RUN:   if (redirect && (outst_d != '0)) state_d = S_DRAIN;
            // Leave as soon as nothing is in flight, even on a repeated
            // redirect, so the unit cannot park in DRAIN with no traffic.
            S_DRAIN: if (outst_d == '0) state_d = S_RUN;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= S_IDLE;
            pc_req_q <= RESET_PC;
            outst_q  <= '0;
            cnt_q    <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            mis_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_req_q <= pc_req_d;
            outst_q  <= outst_d;
            cnt_q    <= cnt_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            mis_q    <= mis_d;
        end
    end

    // Buffer storage needs no reset: entries are only visible while cnt_q != 0.
    always_ff @(posedge i_clk) begin
        if (push) begin
            fifo_insn_q[wr_ptr_q] <= i_imem_rdata;
            fifo_pc_q[wr_ptr_q]   <= pc_rsp;
        end
    end

    assign o_imem_addr   = pc_req_q;
    assign o_insn_vld    = (cnt_q != '0);
    assign o_instruction = o_insn_vld ? fifo_insn_q[rd_ptr_q] : NOP;
    assign o_pc          = o_insn_vld ? fifo_pc_q[rd_ptr_q] : 32'h0;
    assign o_misalign    = mis_q;

    a_no_overflow : assert property (@(posedge i_clk) disable iff (!i_rst_n)
        !(push && (cnt_q == CW'(FIFO_DEPTH))));

endmodule
